// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: write-side and transmitter-side handshake bundle for the UART feeder.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    logic                       wr_en;
    logic [7:0]                 wr_byte;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       overflow;
    logic                       tx_dv;
    logic [7:0]                 tx_byte;
    logic                       tx_active;
    logic                       tx_done;
    logic                       busy;
    logic                       tx_error;
    modport master (
        output wr_en, wr_byte, tx_active, tx_done,
        input  full, empty, count, overflow, tx_dv, tx_byte, busy, tx_error
    );
    modport slave (
        input  wr_en, wr_byte, tx_active, tx_done,
        output full, empty, count, overflow, tx_dv, tx_byte, busy, tx_error
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transmitter over DV/Active/Done,
// with optional inter-byte gap and an ACK timeout that drops an unacknowledged byte.
module uart_tx_feeder #(
    parameter int DEPTH       = 16,
    parameter int GAP_CLKS    = 0,
    parameter int ACK_TIMEOUT = 8
) (
    input logic             i_Clock,
    input logic             i_Reset,
    uart_tx_feeder_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int TMAX = (ACK_TIMEOUT > GAP_CLKS) ? ACK_TIMEOUT : GAP_CLKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_ACT  = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_GAP       = 2'd3;
    localparam logic [1:0] S_AFTER     = (GAP_CLKS > 0) ? S_GAP : S_IDLE;
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CLKS - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          full, empty, overflow;
    logic [1:0]    state;
    logic [TW-1:0] tmr;
    logic          tx_dv, tx_error;
    logic [7:0]    tx_byte;
    logic          push, pop;

    always_comb begin
        push      = bus.wr_en && !full;
        pop       = (state == S_IDLE) && !empty && !bus.tx_active && !bus.tx_done;
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            full     <= count_nxt == CW'(DEPTH);
            empty    <= count_nxt == '0;
            overflow <= bus.wr_en && full;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= bus.wr_byte;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= S_IDLE;
            tmr      <= '0;
            tx_dv    <= 1'b0;
            tx_error <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            tx_dv    <= pop;
            tx_error <= 1'b0;
            if (pop) tx_byte <= mem[rd_ptr];
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_WAIT_ACT;
                        tmr   <= '0;
                    end
                end
                S_WAIT_ACT: begin
                    // A Done arriving before Active means the whole frame already finished.
                    if (bus.tx_done) begin
                        state <= S_AFTER;
                        tmr   <= '0;
                    end else if (bus.tx_active) begin
                        state <= S_WAIT_DONE;
                    end else if (tmr == ACK_LAST) begin
                        state    <= S_IDLE;
                        tx_error <= 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        state <= S_AFTER;
                        tmr   <= '0;
                    end
                end
                default: begin
                    if (tmr == GAP_LAST) state <= S_IDLE;
                    else tmr <= tmr + 1'b1;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.tx_dv    = tx_dv;
    assign bus.tx_byte  = tx_byte;
    assign bus.tx_error = tx_error;
    assign bus.busy     = state != S_IDLE;
endmodule
